vm_transaction_engine: RTL and testbench

Parametrised, registered successor to the vending-machine next-state calculator. Holds the running credit, accepts one-hot coin and item strobes, and dispenses items. It runs an inactivity timer and returns change one coin per cycle, largest coin first. It sits between the coin/item front panel and the top-level vending_machine, and owns all credit state.

---
 rtl/vm_transaction_engine.sv | 169 ++++++++++++++++
 tb/tb_vm_transaction_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_transaction_engine.sv
// Vending-machine transaction engine: owns the credit register, serves coin and item
// strobes, runs the inactivity timer and pays change out greedily, largest coin first.
module vm_transaction_engine #(
  parameter int NUM_COINS   = 3,
  parameter int NUM_ITEMS   = 4,
  parameter int TOTAL_BITS  = 31,
  parameter int WAIT_CYCLES = 100
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_COINS*32-1:0] i_coin_value,
  input  logic [NUM_ITEMS*32-1:0] i_item_price,
  input  logic [NUM_COINS-1:0]    i_input_coin,
  input  logic [NUM_ITEMS-1:0]    i_select_item,
  input  logic                    i_trigger_return,
  output logic [NUM_ITEMS-1:0]    o_available_item,
  output logic [NUM_ITEMS-1:0]    o_output_item,
  output logic                    o_reject_coin,
  output logic [NUM_COINS-1:0]    o_return_coin,
  output logic [TOTAL_BITS-1:0]   o_return_total,
  output logic [TOTAL_BITS-1:0]   o_current_total,
  output logic                    o_busy
);

  localparam int TW = $clog2(WAIT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RETURN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [TOTAL_BITS-1:0]   credit_q, credit_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [NUM_ITEMS-1:0]    output_item_q, output_item_d;
  logic                    reject_q, reject_d;
  logic [NUM_COINS-1:0]    return_coin_q, return_coin_d;
  logic [TOTAL_BITS-1:0]   return_total_q, return_total_d;

  logic [TOTAL_BITS-1:0]   coin_val [NUM_COINS];
  logic [TOTAL_BITS-1:0]   price    [NUM_ITEMS];
  logic [NUM_ITEMS-1:0]    avail;
  logic                    coin_strobe, sel_strobe, in_txn;
  logic [TOTAL_BITS-1:0]   coin_amt, sel_price, post_sel, txn_credit, pay_amt;
  logic [TOTAL_BITS:0]     coin_sum;
  logic                    dispense, coin_ovf, coin_accept, go_return, pay_found;
  logic [NUM_COINS-1:0]    pay_coin;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
    return (v == '0) ? v : v - TW'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_COINS; k++) coin_val[k] = TOTAL_BITS'(i_coin_value[32*k +: 32]);
    for (int j = 0; j < NUM_ITEMS; j++) price[j] = TOTAL_BITS'(i_item_price[32*j +: 32]);
  end

  // Transaction datapath: dispense is judged on the registered credit, the coin
  // overflow check on the post-dispense value.
  always_comb begin
    in_txn      = (state_q != ST_RETURN);
    coin_strobe = $onehot(i_input_coin);
    sel_strobe  = $onehot(i_select_item);
    coin_amt    = '0;
    sel_price   = '0;
    for (int k = 0; k < NUM_COINS; k++)
      if (coin_strobe && i_input_coin[k]) coin_amt = coin_val[k];
    for (int j = 0; j < NUM_ITEMS; j++) begin
      avail[j] = in_txn && (credit_q >= price[j]);
      if (sel_strobe && i_select_item[j]) sel_price = price[j];
    end
    dispense    = sel_strobe && |(i_select_item & avail);
    post_sel    = dispense ? (credit_q - sel_price) : credit_q;
    coin_sum    = {1'b0, post_sel} + {1'b0, coin_amt};
    coin_ovf    = coin_sum[TOTAL_BITS];
    coin_accept = in_txn && coin_strobe && !coin_ovf;
    txn_credit  = coin_accept ? coin_sum[TOTAL_BITS-1:0] : post_sel;
    go_return   = (state_q == ST_ACTIVE) &&
                  (i_trigger_return || ((timer_q == '0) && !coin_accept && !dispense));
  end

  // Greedy payout: ascending scan, so the last fitting coin is the largest one.
  always_comb begin
    pay_coin = '0;
    pay_amt  = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if ((credit_q != '0) && (coin_val[k] <= credit_q)) begin
        pay_coin    = '0;
        pay_coin[k] = 1'b1;
        pay_amt     = coin_val[k];
      end
    end
    pay_found = |pay_coin;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (coin_accept || dispense) state_d = ST_ACTIVE;
      ST_ACTIVE: if (go_return) state_d = (txn_credit == '0) ? ST_IDLE : ST_RETURN;
      ST_RETURN: if (!pay_found) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    credit_d       = credit_q;
    timer_d        = timer_q;
    output_item_d  = '0;
    reject_d       = 1'b0;
    return_coin_d  = '0;
    return_total_d = return_total_q;
    if (in_txn) begin
      credit_d      = txn_credit;
      output_item_d = dispense ? i_select_item : '0;
      reject_d      = coin_strobe && coin_ovf;
      if (coin_accept || dispense)  timer_d = TIMER_RELOAD;
      else if (state_q == ST_ACTIVE) timer_d = dec_sat(timer_q);
      if (go_return) begin
        timer_d        = '0;
        return_total_d = '0;
      end
    end else begin
      reject_d = coin_strobe;
      if (pay_found) begin
        credit_d       = credit_q - pay_amt;
        return_coin_d  = pay_coin;
        return_total_d = return_total_q + pay_amt;
      end else begin
        credit_d = '0;
        timer_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      credit_q       <= '0;
      timer_q        <= '0;
      output_item_q  <= '0;
      reject_q       <= 1'b0;
      return_coin_q  <= '0;
      return_total_q <= '0;
    end else begin
      credit_q       <= credit_d;
      timer_q        <= timer_d;
      output_item_q  <= output_item_d;
      reject_q       <= reject_d;
      return_coin_q  <= return_coin_d;
      return_total_q <= return_total_d;
    end
  end

  assign o_available_item = avail;
  assign o_output_item    = output_item_q;
  assign o_reject_coin    = reject_q;
  assign o_return_coin    = return_coin_q;
  assign o_return_total   = return_total_q;
  assign o_current_total  = credit_q;
  assign o_busy           = (state_q == ST_RETURN);

endmodule

// File: tb/tb_vm_transaction_engine.sv
// Bench for vm_transaction_engine: directed scenarios then random strobes, every cycle
// compared against a cycle-level behavioural model of the vending rules.
module tb_vm_transaction_engine;

  localparam int  NC = 3;
  localparam int  NI = 4;
  localparam int  TB = 31;
  localparam int  W  = 5;
  localparam longint MAXC = (64'd1 << TB) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NC*32-1:0] i_coin_value;
  logic [NI*32-1:0] i_item_price;
  logic [NC-1:0] i_input_coin = '0;
  logic [NI-1:0] i_select_item = '0;
  logic          i_trigger_return = 1'b0;
  logic [NI-1:0] o_available_item;
  logic [NI-1:0] o_output_item;
  logic          o_reject_coin;
  logic [NC-1:0] o_return_coin;
  logic [TB-1:0] o_return_total;
  logic [TB-1:0] o_current_total;
  logic          o_busy;

  vm_transaction_engine #(
    .NUM_COINS(NC), .NUM_ITEMS(NI), .TOTAL_BITS(TB), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_coin_value(i_coin_value), .i_item_price(i_item_price),
    .i_input_coin(i_input_coin), .i_select_item(i_select_item),
    .i_trigger_return(i_trigger_return),
    .o_available_item(o_available_item), .o_output_item(o_output_item),
    .o_reject_coin(o_reject_coin), .o_return_coin(o_return_coin),
    .o_return_total(o_return_total), .o_current_total(o_current_total),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stepno = 0;

  longint cv[NC];
  longint pr[NI];

  // Reference model state: 0 idle, 1 active, 2 paying out
  int     m_state;
  longint m_credit, m_timer, m_total;
  logic [NI-1:0] m_item;
  logic          m_rej;
  logic [NC-1:0] m_rcoin;

  task automatic drive_values();
    i_coin_value = {32'(cv[2]), 32'(cv[1]), 32'(cv[0])};
    i_item_price = {32'(pr[3]), 32'(pr[2]), 32'(pr[1]), 32'(pr[0])};
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d observed=%0d expected=%0d", tag, stepno, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NI-1:0] av;
    for (int j = 0; j < NI; j++) av[j] = (m_state != 2) && (m_credit >= pr[j]);
    chk("current_total", 64'(o_current_total), 64'(m_credit));
    chk("available_item", 64'(o_available_item), 64'(av));
    chk("output_item", 64'(o_output_item), 64'(m_item));
    chk("reject_coin", 64'(o_reject_coin), 64'(m_rej));
    chk("return_coin", 64'(o_return_coin), 64'(m_rcoin));
    chk("return_total", 64'(o_return_total), 64'(m_total));
    chk("busy", 64'(o_busy), 64'(m_state == 2));
  endtask

  task automatic model(input logic [NC-1:0] coin, input logic [NI-1:0] sel, input logic trig);
    bit cvld, svld, acc, disp, ret, found;
    int ci, si;
    longint c;
    cvld = ($countones(coin) == 1);
    svld = ($countones(sel) == 1);
    ci = 0; si = 0;
    for (int k = 0; k < NC; k++) if (coin[k]) ci = k;
    for (int j = 0; j < NI; j++) if (sel[j]) si = j;
    m_item = '0; m_rej = 1'b0; m_rcoin = '0;
    if (m_state == 2) begin
      if (cvld) m_rej = 1'b1;
      found = 0;
      for (int k = NC - 1; k >= 0; k--) begin
        if (!found && m_credit > 0 && cv[k] <= m_credit) begin
          found = 1;
          m_rcoin[k] = 1'b1;
          m_credit -= cv[k];
          m_total += cv[k];
        end
      end
      if (!found) begin
        m_credit = 0;
        m_state = 0;
      end
    end else begin
      disp = svld && (m_credit >= pr[si]);
      c = disp ? m_credit - pr[si] : m_credit;
      acc = 0;
      if (cvld) begin
        if (c + cv[ci] > MAXC) m_rej = 1'b1;
        else begin
          c += cv[ci];
          acc = 1;
        end
      end
      if (disp) m_item = sel;
      ret = (m_state == 1) && (trig || (m_timer == 0 && !acc && !disp));
      if (acc || disp) m_timer = W;
      else if (m_state == 1 && m_timer > 0) m_timer--;
      if (m_state == 0 && (acc || disp)) m_state = 1;
      if (ret) begin
        m_total = 0;
        m_state = (c == 0) ? 0 : 2;
      end
      m_credit = c;
    end
  endtask

  task automatic step(input logic [NC-1:0] coin, input logic [NI-1:0] sel, input logic trig);
    i_input_coin = coin;
    i_select_item = sel;
    i_trigger_return = trig;
    model(coin, sel, trig);
    @(posedge clk);
    #1;
    stepno++;
    check_all();
  endtask

  task automatic reset_step();
    reset_n = 1'b0;
    i_input_coin = '0;
    i_select_item = '0;
    i_trigger_return = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_state = 0; m_credit = 0; m_timer = 0; m_total = 0;
    m_item = '0; m_rej = 1'b0; m_rcoin = '0;
    stepno++;
    check_all();
  endtask

  initial begin
    logic [NC-1:0] rc;
    logic [NI-1:0] rs;
    int r;
    cv[0] = 100; cv[1] = 500; cv[2] = 1000;
    pr[0] = 400; pr[1] = 500; pr[2] = 1000; pr[3] = 2000;
    drive_values();

    // Reset, idle, and a trigger while idle
    reset_step();
    for (int i = 0; i < 10; i++) step('0, '0, 1'b0);
    step('0, '0, 1'b1);

    // Insert 1000, select item1, then coin 100 plus item0 together
    step(3'b100, '0, 1'b0);
    chk("avail_after_1000", 64'(o_available_item), 64'(4'b0111));
    step('0, 4'b0010, 1'b0);
    chk("credit_after_item1", 64'(o_current_total), 64'd500);
    step(3'b001, 4'b0001, 1'b0);
    chk("credit_coin_and_select", 64'(o_current_total), 64'd200);

    // Build 1700 and request change: 1000,500,100,100 then exit
    step(3'b100, '0, 1'b0);
    step(3'b010, '0, 1'b0);
    step('0, '0, 1'b1);
    for (int i = 0; i < 6; i++) step('0, '0, 1'b0);
    chk("return_total_1700", 64'(o_return_total), 64'd1700);

    // Insert 500, let the timer expire, insert a coin during payout
    step(3'b010, '0, 1'b0);
    for (int i = 0; i < 6; i++) step('0, '0, 1'b0);
    step(3'b001, '0, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);

    // Multi-hot strobes are ignored
    step(3'b011, '0, 1'b0);
    step(3'b100, 4'b0011, 1'b0);
    step('0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b0);

    // Overflow boundary using a temporarily huge top coin
    reset_step();
    cv[2] = MAXC + 1 - 200;
    drive_values();
    step(3'b100, '0, 1'b0);
    cv[2] = 1000;
    drive_values();
    step(3'b100, '0, 1'b0);
    step(3'b001, '0, 1'b0);
    step(3'b010, '0, 1'b0);
    step(3'b001, '0, 1'b0);
    chk("credit_at_ceiling", 64'(o_current_total), 64'(MAXC - 99));

    // Reset in the middle of a long payout
    step('0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step('0, '0, 1'b0);
    reset_step();
    step('0, '0, 1'b0);

    // Random strobes against the model
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: rc = 3'b001;
        1: rc = 3'b010;
        2: rc = 3'b100;
        3: rc = 3'b011;
        4: rc = 3'b111;
        default: rc = '0;
      endcase
      r = $urandom_range(0, 11);
      case (r)
        0: rs = 4'b0001;
        1: rs = 4'b0010;
        2: rs = 4'b0100;
        3: rs = 4'b1000;
        4: rs = 4'b0011;
        default: rs = '0;
      endcase
      step(rc, rs, ($urandom_range(0, 39) == 0));
      if (i == 300) reset_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
